// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire slave and master.
// Holds the FSM state encoding, the bus timing constants in microseconds and
// the helper that turns microseconds into clock cycles.
package onewire_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST_LOW,
        PRES_WAIT,
        PRES_DRIVE,
        CMD,
        RX,
        TX
    } ow_state_e;

    // Bus timing in microseconds.
    localparam int unsigned T_RST_MIN = 480;
    localparam int unsigned T_PD_WAIT = 30;
    localparam int unsigned T_PD_LOW  = 120;
    localparam int unsigned T_SAMPLE  = 30;
    localparam int unsigned T_TX0     = 30;

    // cycles = us * clk_hz / 1e6, computed in 64 bits so high clock rates
    // cannot overflow the product.
    function automatic int unsigned us_to_cycles(input int unsigned us,
                                                 input int unsigned clk_hz);
        logic [63:0] prod;
        prod = (64'(us) * 64'(clk_hz)) / 64'd1_000_000;
        return prod[31:0];
    endfunction

endpackage

// File: rtl/onewire_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus level plus one-cycle edge
// pulses derived from the synchronized level.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   i_async   - raw asynchronous input
//   o_level   - synchronized level (two cycles behind the pin)
//   o_fall    - one-cycle pulse on a synchronized 1->0 transition
//   o_rise    - one-cycle pulse on a synchronized 0->1 transition
module onewire_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_fall,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Reset to 1: an idle 1-Wire bus is pulled high, so no false edge
    // appears when reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_fall  = r_prev & ~r_sync;
    assign o_rise  = ~r_prev & r_sync;

endmodule

// File: rtl/onewire_slave.sv
// 1-Wire slave: answers master reset pulses with a presence pulse, receives a
// command byte, then either receives data bytes or transmits bytes supplied
// by the host logic.
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   I_ONE_WIRE    - sensed bus level (asynchronous)
//   O_ONE_WIRE    - bus drive, 0 pulls low, 1 releases
//   i_tx_data     - next byte to transmit, captured while o_tx_req is high
//   o_tx_req      - one-cycle pulse, i_tx_data captured this cycle
//   o_cmd         - last received command byte, o_cmd_valid pulses on update
//   o_rx_data     - last received data byte, o_rx_valid pulses on update
//   o_reset_seen  - one-cycle pulse when a valid reset pulse ends
//   o_busy        - high whenever the FSM is not IDLE
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | after reset; falling edges ignored, only a bus reset acts
// RST_LOW    | bus held low long enough for a reset; wait for release
// PRES_WAIT  | delay before the presence pulse
// PRES_DRIVE | driving the presence pulse low
// CMD        | receiving the command byte
// RX         | receiving data bytes until the next bus reset
// TX         | transmitting host bytes, one bit per master read slot
module onewire_slave
    import onewire_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 12_000_000,
    parameter logic [7:0]  READ_CMD = 8'hBE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       I_ONE_WIRE,
    output logic       O_ONE_WIRE,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_req,
    output logic [7:0] o_cmd,
    output logic       o_cmd_valid,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_reset_seen,
    output logic       o_busy
);

    localparam int unsigned C_RST     = us_to_cycles(T_RST_MIN, CLK_HZ);
    localparam int unsigned C_PD_WAIT = us_to_cycles(T_PD_WAIT, CLK_HZ);
    localparam int unsigned C_PD_LOW  = us_to_cycles(T_PD_LOW, CLK_HZ);
    localparam int unsigned C_SAMPLE  = us_to_cycles(T_SAMPLE, CLK_HZ);
    localparam int unsigned C_TX0     = us_to_cycles(T_TX0, CLK_HZ);
    localparam int          CW        = $clog2(C_RST + 1);

    // Down-counter reload values: a count of N cycles loads N-1 and
    // finishes on the cycle the timer reads zero.
    localparam logic [CW-1:0] L_RST     = CW'(C_RST);
    localparam logic [CW-1:0] L_PD_WAIT = CW'(C_PD_WAIT - 1);
    localparam logic [CW-1:0] L_PD_LOW  = CW'(C_PD_LOW - 1);
    localparam logic [CW-1:0] L_SAMPLE  = CW'(C_SAMPLE - 1);
    localparam logic [CW-1:0] L_TX0     = CW'(C_TX0 - 1);

    ow_state_e       r_state;
    ow_state_e       w_state_nxt;

    logic            w_level;
    logic            w_fall;
    logic            w_rise;

    logic [CW-1:0]   r_low_cnt;
    logic [CW-1:0]   r_timer;
    logic            r_slot_active;
    logic            r_wait_high;
    logic            r_tx_drive;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [7:0]      r_tx_sh;
    logic [7:0]      r_cmd;
    logic [7:0]      r_rx_data;
    logic            r_cmd_valid;
    logic            r_rx_valid;
    logic            r_reset_seen;

    logic            w_rst_det;
    logic            w_in_slot_state;
    logic            w_slot_start;
    logic            w_slot_end;
    logic            w_byte_end;
    logic            w_tx_load;
    logic [7:0]      w_byte;

    onewire_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (I_ONE_WIRE),
        .o_level (w_level),
        .o_fall  (w_fall),
        .o_rise  (w_rise)
    );

    // Our own presence pulse must not look like a master reset, so the low
    // counter is held clear while we drive it.
    assign w_rst_det = !w_level && (r_low_cnt == L_RST) && (r_state != PRES_DRIVE);

    assign w_in_slot_state = (r_state == CMD) || (r_state == RX) || (r_state == TX);
    assign w_byte          = {w_level, r_shift[7:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_slot_start = 1'b0;
        w_slot_end   = 1'b0;
        w_byte_end   = 1'b0;
        w_tx_load    = 1'b0;
        case (r_state)
            IDLE: begin
            end
            RST_LOW: begin
                if (w_rise) w_state_nxt = PRES_WAIT;
            end
            PRES_WAIT: begin
                if (r_timer == '0) w_state_nxt = PRES_DRIVE;
            end
            PRES_DRIVE: begin
                if (r_timer == '0) w_state_nxt = CMD;
            end
            CMD, RX, TX: begin
                // Edges arriving mid-slot or before the line recovers are ignored.
                w_slot_start = w_fall && !r_slot_active && !r_wait_high;
                w_slot_end   = r_slot_active && (r_timer == '0);
                w_byte_end   = w_slot_end && (r_bit_cnt == 3'd7);
                if (r_state == CMD && w_byte_end) begin
                    if (w_byte == READ_CMD) begin
                        w_state_nxt = TX;
                        w_tx_load   = 1'b1;
                    end else begin
                        w_state_nxt = RX;
                    end
                end
                if (r_state == TX && w_byte_end) w_tx_load = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
        // A long enough low aborts whatever is in progress.
        if (w_rst_det) begin
            w_state_nxt  = RST_LOW;
            w_slot_start = 1'b0;
            w_slot_end   = 1'b0;
            w_byte_end   = 1'b0;
            w_tx_load    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_low_cnt     <= '0;
            r_timer       <= '0;
            r_slot_active <= 1'b0;
            r_wait_high   <= 1'b0;
            r_tx_drive    <= 1'b0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_tx_sh       <= '0;
            r_cmd         <= '0;
            r_rx_data     <= '0;
            r_cmd_valid   <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_reset_seen  <= 1'b0;
        end else begin
            r_cmd_valid  <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_reset_seen <= (r_state == RST_LOW) && w_rise;

            if (w_level || r_state == PRES_DRIVE) begin
                r_low_cnt <= '0;
            end else if (r_low_cnt != L_RST) begin
                r_low_cnt <= r_low_cnt + 1'b1;
            end

            if (w_state_nxt == PRES_WAIT && r_state != PRES_WAIT) begin
                r_timer <= L_PD_WAIT;
            end else if (w_state_nxt == PRES_DRIVE && r_state != PRES_DRIVE) begin
                r_timer <= L_PD_LOW;
            end else if (w_slot_start) begin
                r_timer <= (r_state == TX) ? L_TX0 : L_SAMPLE;
            end else if (r_timer != '0) begin
                r_timer <= r_timer - 1'b1;
            end

            if (w_rst_det || !w_in_slot_state) begin
                r_slot_active <= 1'b0;
                r_wait_high   <= 1'b0;
                r_tx_drive    <= 1'b0;
            end else if (w_slot_start) begin
                r_slot_active <= 1'b1;
                r_tx_drive    <= (r_state == TX) && !r_tx_sh[0];
            end else if (w_slot_end) begin
                r_slot_active <= 1'b0;
                r_wait_high   <= 1'b1;
                r_tx_drive    <= 1'b0;
            end else if (r_wait_high && w_level) begin
                r_wait_high   <= 1'b0;
            end

            if (w_rst_det || r_state == RST_LOW) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_slot_end) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_state != TX) r_shift <= w_byte;
                if (w_byte_end && r_state == CMD) begin
                    r_cmd       <= w_byte;
                    r_cmd_valid <= 1'b1;
                end
                if (w_byte_end && r_state == RX) begin
                    r_rx_data  <= w_byte;
                    r_rx_valid <= 1'b1;
                end
            end

            if (w_tx_load) begin
                r_tx_sh <= i_tx_data;
            end else if (w_slot_end && r_state == TX) begin
                r_tx_sh <= {1'b0, r_tx_sh[7:1]};
            end
        end
    end

    assign O_ONE_WIRE   = !((r_state == PRES_DRIVE) || r_tx_drive);
    assign o_tx_req     = w_tx_load;
    assign o_cmd        = r_cmd;
    assign o_cmd_valid  = r_cmd_valid;
    assign o_rx_data    = r_rx_data;
    assign o_rx_valid   = r_rx_valid;
    assign o_reset_seen = r_reset_seen;
    assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_onewire_slave.sv
// Bench for onewire_slave: a behavioural 1-Wire master drives the bus
// (wired-AND with the DUT drive), expected bytes and bits are queued when the
// stimulus is issued and consumed when the DUT reports them.
module tb_onewire_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       master_low;
    logic       I_ONE_WIRE;
    logic       O_ONE_WIRE;
    logic [7:0] i_tx_data;
    logic       o_tx_req;
    logic [7:0] o_cmd;
    logic       o_cmd_valid;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_reset_seen;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_reset_seen = 0;
    int n_tx_req = 0;
    int n_cmd_valid = 0;
    int n_rx_valid = 0;

    logic [7:0] exp_cmd[$];
    logic [7:0] exp_rx[$];
    bit         exp_bit[$];

    always #5 clk = ~clk;

    assign I_ONE_WIRE = master_low ? 1'b0 : O_ONE_WIRE;

    onewire_slave #(
        .CLK_HZ   (12_000_000),
        .READ_CMD (8'hBE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .I_ONE_WIRE   (I_ONE_WIRE),
        .O_ONE_WIRE   (O_ONE_WIRE),
        .i_tx_data    (i_tx_data),
        .o_tx_req     (o_tx_req),
        .o_cmd        (o_cmd),
        .o_cmd_valid  (o_cmd_valid),
        .o_rx_data    (o_rx_data),
        .o_rx_valid   (o_rx_valid),
        .o_reset_seen (o_reset_seen),
        .o_busy       (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: counts pulses and pops the scoreboard on byte reports.
    initial forever begin
        @(negedge clk);
        if (o_reset_seen) n_reset_seen++;
        if (o_tx_req) n_tx_req++;
        if (o_cmd_valid) begin
            n_cmd_valid++;
            if (exp_cmd.size() == 0) check("cmd_unexpected", 32'(o_cmd), 32'hFFFF_FFFF);
            else check("cmd_byte", 32'(o_cmd), 32'(exp_cmd.pop_front()));
        end
        if (o_rx_valid) begin
            n_rx_valid++;
            if (exp_rx.size() == 0) check("rx_unexpected", 32'(o_rx_data), 32'hFFFF_FFFF);
            else check("rx_byte", 32'(o_rx_data), 32'(exp_rx.pop_front()));
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic write_bit(input bit b);
        master_low = 1'b1;
        repeat (b ? 6 : 720) @(negedge clk);
        master_low = 1'b0;
        repeat (b ? 834 : 120) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) write_bit(v[i]);
    endtask

    task automatic push_tx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) exp_bit.push_back(v[i]);
    endtask

    // Read slot: 12-cycle master low, sample at 180, 840-cycle slot.
    task automatic read_slot();
        logic b;
        int   nlow;
        bit   e;
        b    = 1'b0;
        nlow = 0;
        master_low = 1'b1;
        for (int i = 0; i < 840; i++) begin
            if (i == 12) master_low = 1'b0;
            if (i == 180) b = I_ONE_WIRE;
            if (!O_ONE_WIRE) nlow++;
            @(negedge clk);
        end
        if (exp_bit.size() == 0) begin
            check("tx_bit_unexpected", 32'(b), 32'd2);
        end else begin
            e = exp_bit.pop_front();
            check("tx_bit", 32'(b), 32'(e));
            check("tx_low_len", nlow, e ? 0 : 360);
        end
    endtask

    // Master reset pulse of 6000 cycles, then measure the DUT response.
    task automatic bus_reset();
        int  t0, t_seen, t_fall, nlow;
        bit  ok;
        t_seen = 0;
        t_fall = 0;
        master_low = 1'b1;
        repeat (6000) @(negedge clk);
        master_low = 1'b0;
        t0 = cyc;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (o_reset_seen) begin
                ok = 1'b1;
                t_seen = cyc;
            end
        end
        check("reset_seen_found", 32'(ok), 1);
        if (!ok) return;
        check("reset_seen_lat", t_seen - t0, 3);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (!O_ONE_WIRE) begin
                ok = 1'b1;
                t_fall = cyc;
            end
        end
        check("presence_found", 32'(ok), 1);
        if (!ok) return;
        check("presence_delay", t_fall - t_seen, 360);
        nlow = 0;
        for (int i = 0; i < 2000 && !O_ONE_WIRE; i++) begin
            nlow++;
            @(negedge clk);
        end
        check("presence_len", nlow, 1440);
        repeat (5) @(negedge clk);
        check("state_cmd", 32'(dut.r_state), 32'(onewire_pkg::CMD));
        check("busy_cmd", 32'(o_busy), 1);
    endtask

    initial begin
        int         c0, r0, rs0, t0;
        logic [7:0] v;
        rst        = 1'b1;
        master_low = 1'b0;
        i_tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_bus", 32'(O_ONE_WIRE), 1);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_cmd", 32'(o_cmd), 0);
        check("rst_rx", 32'(o_rx_data), 0);
        check("rst_pulses", 32'({o_cmd_valid, o_rx_valid, o_reset_seen, o_tx_req}), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Falling edges in IDLE are ignored.
        write_bit(1'b0);
        check("idle_busy", 32'(o_busy), 0);
        check("idle_no_cmd", n_cmd_valid, 0);

        bus_reset();
        check("reset_seen_count", n_reset_seen, 1);

        c0 = n_cmd_valid;
        exp_cmd.push_back(8'h44);
        write_byte(8'h44);
        check("cmd_valid_once", n_cmd_valid - c0, 1);
        check("cmd_reg", 32'(o_cmd), 32'h44);
        check("state_rx", 32'(dut.r_state), 32'(onewire_pkg::RX));

        r0 = n_rx_valid;
        exp_rx.push_back(8'hA5);
        write_byte(8'hA5);
        check("rx_valid_once", n_rx_valid - r0, 1);
        check("rx_reg", 32'(o_rx_data), 32'hA5);

        // A 5000-cycle low is a 0 bit, not a reset.
        rs0 = n_reset_seen;
        r0  = n_rx_valid;
        v   = 8'h5A;
        exp_rx.push_back(v);
        master_low = 1'b1;
        repeat (5000) @(negedge clk);
        master_low = 1'b0;
        repeat (120) @(negedge clk);
        for (int i = 1; i < 8; i++) write_bit(v[i]);
        check("long_low_no_reset", n_reset_seen - rs0, 0);
        check("long_low_rx_once", n_rx_valid - r0, 1);
        check("long_low_rx_reg", 32'(o_rx_data), 32'h5A);

        // Reset out of RX, then abort a command mid-byte with another reset.
        bus_reset();
        c0  = n_cmd_valid;
        rs0 = n_reset_seen;
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        bus_reset();
        check("abort_no_cmd", n_cmd_valid - c0, 0);
        check("abort_reset_seen", n_reset_seen - rs0, 1);

        // Read command, then continuous transmit from host bytes.
        t0 = n_tx_req;
        c0 = n_cmd_valid;
        i_tx_data = 8'h3C;
        push_tx(8'h3C);
        exp_cmd.push_back(8'hBE);
        write_byte(8'hBE);
        check("read_cmd_once", n_cmd_valid - c0, 1);
        check("state_tx", 32'(dut.r_state), 32'(onewire_pkg::TX));
        check("tx_req_cmd", n_tx_req - t0, 1);
        i_tx_data = 8'h81;
        push_tx(8'h81);
        for (int i = 0; i < 8; i++) read_slot();
        check("tx_req_byte1", n_tx_req - t0, 2);
        i_tx_data = 8'h00;
        for (int i = 0; i < 8; i++) read_slot();
        check("tx_req_byte2", n_tx_req - t0, 3);

        // Synchronous reset while driving a 0 bit.
        master_low = 1'b1;
        repeat (100) @(negedge clk);
        check("tx0_driving", 32'(O_ONE_WIRE), 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_bus", 32'(O_ONE_WIRE), 1);
        check("rst_mid_busy", 32'(o_busy), 0);
        check("rst_mid_state", 32'(dut.r_state), 32'(onewire_pkg::IDLE));
        master_low = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check("cmd_queue_empty", exp_cmd.size(), 0);
        check("rx_queue_empty", exp_rx.size(), 0);
        check("tx_queue_empty", exp_bit.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/onewire_slave.md
Name: onewire_slave

Overview:
- 1-Wire responder (slave) for the other end of the workshop one-wire master; used as a synthesizable bus partner on a second board and as a behavioural-accurate mock in simulation.
- Detects master reset pulses, answers with a presence pulse, receives a command byte, then either streams received bytes out or transmits bytes supplied by the host logic.
- Open-drain style: drives O_ONE_WIRE low only to pull the bus down; high means released.

Parameters:
- CLK_HZ, 12_000_000, system clock frequency; all timing constants derive from it as cycles = us * CLK_HZ / 1_000_000.
- READ_CMD, 8'hBE, command byte that selects transmit mode; any other command selects receive mode.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- I_ONE_WIRE  input  1  sensed bus level, asynchronous.
- O_ONE_WIRE  output  1  bus drive; 0 = pull low, 1 = release.
- i_tx_data  input  8  next byte to transmit, sampled when o_tx_req pulses.
- o_tx_req  output  1  one-cycle pulse; i_tx_data captured this cycle.
- o_cmd  output  8  last received command byte.
- o_cmd_valid  output  1  one-cycle pulse when o_cmd updates.
- o_rx_data  output  8  last received data byte.
- o_rx_valid  output  1  one-cycle pulse when o_rx_data updates.
- o_reset_seen  output  1  one-cycle pulse when a valid reset pulse ends.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE. O_ONE_WIRE=1. All pulses 0. o_cmd, o_rx_data and the bit counter are 0. The synchronizer flops are set to 1.
- Input: 2-FF synchronizer, then a falling-edge detector. All timing references the synchronized level, so it lags the pin by 2 cycles.
- Timing constants, in us: T_RST_MIN=480, T_PD_WAIT=30, T_PD_LOW=120, T_SAMPLE=30, T_TX0=30.
- Global low counter: counts consecutive low cycles and saturates. If it reaches T_RST_MIN from any state, the FSM enters RST_LOW. This aborts any byte in progress with no valid pulse. O_ONE_WIRE is released unless the FSM is in PRES_DRIVE.
- RST_LOW: wait for the line to go high. On the rising edge, pulse o_reset_seen and go to PRES_WAIT.
- PRES_WAIT: count T_PD_WAIT cycles, then go to PRES_DRIVE.
- PRES_DRIVE: O_ONE_WIRE=0 for T_PD_LOW cycles, then release and go to CMD. Our own presence low does not feed the reset counter, because the counter is held clear in this state.
- CMD and RX slots:
  - A falling edge starts a slot.
  - Sample the bus T_SAMPLE cycles after the edge and shift the bit in LSB first.
  - Then wait for the line to go high before accepting the next edge.
- After 8 bits in CMD:
  - o_cmd is updated and o_cmd_valid pulses.
  - If the byte equals READ_CMD, go to TX and pulse o_tx_req in the same cycle to load the shift register. Otherwise go to RX.
- RX: each 8 bits updates o_rx_data and pulses o_rx_valid. Stays in RX until the next reset pulse.
- TX slots:
  - On a falling edge with current bit 0: O_ONE_WIRE=0 for T_TX0 cycles from edge detection, then release.
  - On a falling edge with current bit 1: no drive.
  - After 8 bits, pulse o_tx_req and reload from i_tx_data. Transmission is continuous and LSB first.
- A falling edge that occurs while still counting a slot is ignored; the current slot continues.
- IDLE: falling edges are ignored. Only a reset pulse is acted on.
- rst asserted mid-slot: O_ONE_WIRE releases on the next clock edge and all state clears.
- Bit counter is 3 bits and wraps 7→0 at byte end.
- Timing counters are sized with $clog2 of (T_RST_MIN cycles + 1).

Decomposition:
- Package onewire_pkg:
  - state enum: IDLE, RST_LOW, PRES_WAIT, PRES_DRIVE, CMD, RX, TX.
  - function us_to_cycles(us, clk_hz).
  - the T_* microsecond constants, shared with the master.
- Sub-module onewire_sync_edge: 2-FF synchronizer plus falling- and rising-edge pulses. It is reusable by the master.

Test Plan (CLK_HZ=12 MHz, 1 us = 12 cycles):
- Master holds low 6000 cycles (500 us), then releases:
  - o_reset_seen pulses 1 cycle after the synchronized rise.
  - O_ONE_WIRE goes 0 after 360 cycles and stays 0 for exactly 1440 cycles.
  - Then state is CMD.
- Reset, then write 0x44 (bit 1: 6-cycle low; bit 0: 720-cycle low; 840-cycle slots):
  - o_cmd=0x44 and o_cmd_valid pulses once.
  - Then write 0xA5: o_rx_data=0xA5 and o_rx_valid pulses once.
- Reset, write 0xBE with i_tx_data=0x3C, then 8 read slots (12-cycle low, sample at 180 cycles):
  - Read bits are 0,0,1,1,1,1,0,0.
  - O_ONE_WIRE low for 360 cycles on each 0 bit.
  - o_tx_req pulses at the command end and again after the 8th slot.
- Low pulse of 5000 cycles (417 us) during RX: treated as a bit slot (0 sampled), no o_reset_seen.
- Mid-byte reset: 4 bits of a command, then a 6000-cycle low:
  - No o_cmd_valid.
  - Presence pulse follows.
  - The next full byte is received correctly as the command.
- rst asserted during a TX 0-bit drive: O_ONE_WIRE=1 the next cycle, o_busy=0, state IDLE.
